// File: rtl/pc_gen.sv
// pc_gen: parametrised fetch-stage program counter with prioritised redirects that are latched
// while fetch is blocked. Define PC_EXC_EN to add exception entry (exc_req) and return (eret).
module pc_gen #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       STEP      = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h380)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_pc,
  input  logic              fetch_ready,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] inst_address,
  output logic [ADDR_W-1:0] next_instaddress,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
`ifdef PC_EXC_EN
  input  logic              exc_req,
  input  logic              eret,
  output logic [ADDR_W-1:0] epc,
`endif
  output logic              misalign_err
);

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

`ifdef PC_EXC_EN
  localparam int unsigned PRI_W = 3;
`else
  localparam int unsigned PRI_W = 2;
`endif

  // Redirect priority levels; zero means no redirect this cycle / nothing pending.
  localparam logic [PRI_W-1:0] PriNone = PRI_W'(0);
  localparam logic [PRI_W-1:0] PriJmp  = PRI_W'(1);
  localparam logic [PRI_W-1:0] PriBr   = PRI_W'(2);
  localparam logic [PRI_W-1:0] PriJr   = PRI_W'(3);
`ifdef PC_EXC_EN
  localparam logic [PRI_W-1:0] PriEret = PRI_W'(4);
  localparam logic [PRI_W-1:0] PriExc  = PRI_W'(5);
`endif

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              fetch_valid_q;
  logic              misalign_q;
  logic [ADDR_W-1:0] pend_tgt_q;
  logic [PRI_W-1:0]  pend_pri_q;

  logic [PRI_W-1:0]  redir_pri;
  logic [ADDR_W-1:0] redir_tgt;
  logic              redir;
  logic              adv;
  logic              take_new;
  logic [ADDR_W-1:0] load_src;
  logic [ADDR_W-1:0] load_pc;
  logic              load_mis;

`ifdef PC_EXC_EN
  logic [ADDR_W-1:0] epc_q;
`else
  logic              unused_exc_vec;
  assign unused_exc_vec = ^EXC_VEC;
`endif

  always_comb begin
    redir_pri = PriNone;
    redir_tgt = '0;
    // Later assignments override earlier ones, which yields the priority order.
    if (jmp) begin
      redir_pri = PriJmp;
      redir_tgt = jmp_target;
    end
    if (br_taken) begin
      redir_pri = PriBr;
      redir_tgt = br_target;
    end
    if (jr) begin
      redir_pri = PriJr;
      redir_tgt = jr_target;
    end
`ifdef PC_EXC_EN
    if (eret) begin
      redir_pri = PriEret;
      redir_tgt = epc_q;
    end
    if (exc_req) begin
      redir_pri = PriExc;
      redir_tgt = EXC_VEC;
    end
`endif
  end

  assign redir    = (redir_pri != PriNone);
  assign adv      = fetch_valid_q & fetch_ready & ~stall_pc;
  // pend_pri_q is zero outside HOLD, so any redirect wins there.
  assign take_new = (redir_pri > pend_pri_q);
  assign load_src = take_new ? redir_tgt : pend_tgt_q;
  assign load_pc  = load_src & ~ALIGN_MASK;
  assign load_mis = |(load_src & ALIGN_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_VEC;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      pend_tgt_q    <= '0;
      pend_pri_q    <= PriNone;
`ifdef PC_EXC_EN
      epc_q         <= RESET_VEC;
`endif
    end else begin
      misalign_q <= 1'b0;
`ifdef PC_EXC_EN
      if (exc_req) epc_q <= pc_q;
`endif
      unique case (state_q)
        StBoot: begin
          fetch_valid_q <= 1'b1;
          if (take_new) begin
            pend_tgt_q <= redir_tgt;
            pend_pri_q <= redir_pri;
            state_q    <= StHold;
          end else begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (adv) begin
            if (redir) begin
              pc_q       <= load_pc;
              misalign_q <= load_mis;
            end else begin
              pc_q <= next_instaddress;
            end
          end else if (redir) begin
            pend_tgt_q <= redir_tgt;
            pend_pri_q <= redir_pri;
            state_q    <= StHold;
          end
        end
        StHold: begin
          if (adv) begin
            pc_q       <= load_pc;
            misalign_q <= load_mis;
            pend_pri_q <= PriNone;
            state_q    <= StRun;
          end else if (take_new) begin
            pend_tgt_q <= redir_tgt;
            pend_pri_q <= redir_pri;
          end
        end
        default: begin
          state_q       <= StBoot;
          fetch_valid_q <= 1'b0;
          pend_pri_q    <= PriNone;
        end
      endcase
    end
  end

  assign fetch_valid      = fetch_valid_q;
  assign inst_address     = pc_q;
  assign next_instaddress = pc_q + ADDR_W'(STEP);
  assign misalign_err     = misalign_q;
`ifdef PC_EXC_EN
  assign epc              = epc_q;
`endif

endmodule
